// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and sequencing controller for the five-stage pipeline.
// Drives capture (en) and bubble (flush) controls for the PC and the IF/ID,
// ID/EX, EX/MEM and MEM/WB latches. It also keeps saturating stall and
// redirect counters.
// Optional feature macro: PIPELINE_CTRL_FORWARDING_EN. When it is defined,
// the datapath forwards results, so only load-use pairs stall. When it is not
// defined, any RAW dependence on ID/EX or EX/MEM stalls.

package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;
endpackage

module pipeline_ctrl
    import cpu_types_pkg::*;
(
    input  logic     CLK,
    input  logic     RST,
    input  logic     ihit,
    input  logic     dhit,
    input  regbits_t ifid_rs,
    input  regbits_t ifid_rt,
    input  logic     ifid_uses_rt,
    input  regbits_t idex_wsel,
    input  logic     idex_regWr,
    input  logic     idex_dREN,
    input  regbits_t exmem_wsel,
    input  logic     exmem_regWr,
    input  logic     exmem_dREN,
    input  logic     exmem_dWEN,
    input  logic     ex_redirect,
    input  logic     memwb_halt,
    output logic     pc_en,
    output logic     ifid_en,
    output logic     ifid_flush,
    output logic     idex_en,
    output logic     idex_flush,
    output logic     idex_freeze,
    output logic     exmem_en,
    output logic     exmem_flush,
    output logic     memwb_en,
    output logic     memwb_flush,
    output logic     halted,
    output word_t    stall_cnt,
    output word_t    flush_cnt
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t state, next_state;
    word_t  stall_count, flush_count;
    logic   raw_hazard;
    logic   dwait;
    logic   stall_event;
    logic   redirect_event;

    // A producer matches an ID source only when the destination register is
    // not $0, because writes to $0 are discarded.
    function automatic logic src_match(input regbits_t wsel, input regbits_t rs,
                                       input regbits_t rt, input logic uses_rt);
        return (wsel != '0) && ((wsel == rs) || (uses_rt && (wsel == rt)));
    endfunction

`ifdef PIPELINE_CTRL_FORWARDING_EN
    // Forwarding covers ALU results, so only a load in EX can still starve ID.
    // The EX/MEM destination does not matter in this build. Its name holds
    // "unused" so that lint accepts the deliberate drop.
    logic [5:0] exmem_unused;
    assign exmem_unused = {exmem_wsel, exmem_regWr};
    assign raw_hazard = idex_dREN && idex_regWr
                        && src_match(idex_wsel, ifid_rs, ifid_rt, ifid_uses_rt);
`else
    // Without forwarding, any pending write in EX or MEM blocks the reader in
    // ID. Write-first register-file behaviour covers WB. Whether the EX
    // instruction is a load does not matter here.
    logic idex_load_unused;
    assign idex_load_unused = idex_dREN;
    assign raw_hazard = (idex_regWr && src_match(idex_wsel, ifid_rs, ifid_rt, ifid_uses_rt))
                     || (exmem_regWr && src_match(exmem_wsel, ifid_rs, ifid_rt, ifid_uses_rt));
`endif

    assign dwait = (exmem_dREN || exmem_dWEN) && !dhit;

    // Priority-ordered latch control. The halt rule comes first, then
    // dcache wait, redirect, RAW hazard, and icache miss. While reset is
    // asserted or the core is halted, everything stays at its safe default.
    always_comb begin
        pc_en          = 1'b0;
        ifid_en        = 1'b0;
        ifid_flush     = 1'b0;
        idex_en        = 1'b0;
        idex_flush     = 1'b0;
        exmem_en       = 1'b0;
        exmem_flush    = 1'b0;
        memwb_en       = 1'b0;
        memwb_flush    = 1'b0;
        stall_event    = 1'b0;
        redirect_event = 1'b0;
        next_state     = state;
        if (!RST && state == RUN) begin
            if (memwb_halt) begin
                ifid_en     = 1'b1;
                ifid_flush  = 1'b1;
                idex_en     = 1'b1;
                idex_flush  = 1'b1;
                exmem_en    = 1'b1;
                exmem_flush = 1'b1;
                memwb_en    = 1'b1;
                next_state  = HALTED;
            end else if (dwait) begin
                memwb_en    = 1'b1;
                memwb_flush = 1'b1;
                stall_event = 1'b1;
            end else if (ex_redirect) begin
                pc_en          = 1'b1;
                ifid_en        = 1'b1;
                ifid_flush     = 1'b1;
                idex_en        = 1'b1;
                idex_flush     = 1'b1;
                exmem_en       = 1'b1;
                memwb_en       = 1'b1;
                redirect_event = 1'b1;
            end else if (raw_hazard) begin
                idex_en     = 1'b1;
                idex_flush  = 1'b1;
                exmem_en    = 1'b1;
                memwb_en    = 1'b1;
                stall_event = 1'b1;
            end else if (!ihit) begin
                ifid_en     = 1'b1;
                ifid_flush  = 1'b1;
                idex_en     = 1'b1;
                exmem_en    = 1'b1;
                memwb_en    = 1'b1;
                stall_event = 1'b1;
            end else begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                idex_en  = 1'b1;
                exmem_en = 1'b1;
                memwb_en = 1'b1;
            end
        end
    end

    assign idex_freeze = !idex_en;

    // The RUN/HALTED state register. HALTED is left only through reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Saturating performance counters. They pin at all-ones instead of
    // wrapping, so a long run never reports a small bogus value.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall_event && (stall_count != '1)) begin
                stall_count <= stall_count + 32'd1;
            end
            if (redirect_event && (flush_count != '1)) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end

    assign halted    = (state == HALTED);
    assign stall_cnt = stall_count;
    assign flush_cnt = flush_count;

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and sequencing controller for the five-stage pipeline. It drives the capture, flush and freeze controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB latches, resolving cache waits, load-use and RAW hazards, control redirects and halt. It also keeps saturating stall and flush performance counters. It sits beside the datapath and consumes only latch-side status signals.

## Interface
- No parameters; widths come from `cpu_types_pkg` (`word_t` = 32 bits, register select = 5 bits).
- `CLK`  in  1  system clock, rising edge.
- `RST`  in  1  reset; asynchronous, active-high.
- `ihit`  in  1  icache delivers the fetched instruction this cycle.
- `dhit`  in  1  dcache completes the EX/MEM access this cycle.
- `ifid_rs`, `ifid_rt`  in  5 each  source registers of the instruction in ID.
- `ifid_uses_rt`  in  1  ID instruction reads `rt`.
- `idex_wsel`  in  5  destination register of the ID/EX instruction.
- `idex_regWr`  in  1  ID/EX instruction writes a register.
- `idex_dREN`  in  1  ID/EX instruction is a load.
- `exmem_wsel`  in  5  destination register of the EX/MEM instruction.
- `exmem_regWr`, `exmem_dREN`, `exmem_dWEN`  in  1 each  EX/MEM status.
- `ex_redirect`  in  1  taken branch or jump resolved in EX.
- `memwb_halt`  in  1  halt instruction is in MEM/WB.
- `pc_en`  out  1  PC loads its next value.
- `ifid_en`, `ifid_flush`  out  1 each  IF/ID capture / capture bubble.
- `idex_en`, `idex_flush`, `idex_freeze`  out  1 each  ID/EX controls; `idex_freeze` = !`idex_en`.
- `exmem_en`, `exmem_flush`  out  1 each  EX/MEM controls.
- `memwb_en`, `memwb_flush`  out  1 each  MEM/WB controls.
- `halted`  out  1  core halted.
- `stall_cnt`  out  32  count of PC-stall cycles.
- `flush_cnt`  out  32  count of redirect cycles.

## Operation
- Latch semantics: en=1 captures the inputs at the edge. en=1 with flush=1 captures a bubble (all control fields 0). en=0 holds. flush is only meaningful when en=1.
- States: RUN and HALTED. RST drives RUN.
- RUN → HALTED at the edge where `memwb_halt`=1 and `memwb_en`=1. HALTED is sticky until RST.
- RUN control, first matching rule wins:
  1. halt: `memwb_halt`=1. `pc_en`=0. IF/ID, ID/EX and EX/MEM get en=1 and flush=1. MEM/WB gets en=1.
  2. dwait: (`exmem_dREN`|`exmem_dWEN`) & !`dhit`. PC, IF/ID, ID/EX and EX/MEM get en=0. MEM/WB gets en=1 and flush=1.
  3. redirect: `ex_redirect`. `pc_en`=1. IF/ID and ID/EX get en=1 and flush=1. EX/MEM and MEM/WB get en=1. This applies regardless of `ihit`.
  4. hazard: the RAW rule in Configuration matches. `pc_en`=0 and `ifid_en`=0. ID/EX gets en=1 and flush=1. EX/MEM and MEM/WB get en=1.
  5. ifetch: !`ihit`. `pc_en`=0. IF/ID gets en=1 and flush=1. All other latches get en=1.
  6. otherwise all en=1 and all flush=0.
- Register matching ignores register 0: a `wsel` of 0 never matches.
- HALTED: every en=0 and every flush=0. `idex_freeze`=1 and `halted`=1. Counters hold.
- `stall_cnt` increments in RUN when `pc_en`=0, excluding rule 1.
- `flush_cnt` increments in RUN on rule 3.
- Both counters saturate at 0xFFFFFFFF.

## Timing
- All control outputs are combinational from the current state and the inputs, with zero latency.
- `halted` and the counters are registered.
- While RST is high, all outputs are forced as follows:
  - every en=0 and every flush=0;
  - `idex_freeze`=1;
  - `halted`=0, `stall_cnt`=0, `flush_cnt`=0.
- RST asserted mid-stall or in HALTED returns to RUN on the first edge after release. No pending hazard is remembered.
- dwait with `ex_redirect` at the same time: dwait wins. The redirect is re-evaluated each cycle until `dhit`, because ID/EX holds.
- Hazard with !`ihit` at the same time: hazard wins. IF/ID holds the valid instruction, and the fetch stays pending because the PC is frozen.
- The load-use stall lasts exactly 1 cycle with forwarding. Without forwarding it lasts up to 2 cycles.

## Configuration
- `PIPELINE_CTRL_FORWARDING_EN` defined:
  - The hazard rule is load-use only: `idex_dREN` & `idex_regWr` & (`idex_wsel`==`ifid_rs` | (`ifid_uses_rt` & `idex_wsel`==`ifid_rt`)).
- Not defined:
  - The hazard rule is a full RAW check: the same source match against ID/EX when `idex_regWr`=1 (load or not), OR against EX/MEM when `exmem_regWr`=1.
  - WB→ID is assumed to be covered by write-first register-file behaviour.

## Test plan
- Reset: hold RST high for 3 cycles with random inputs → all en=0, `idex_freeze`=1, counters 0. Release with `ihit`=1 and no hazards → all en=1 on the next cycle.
- Load-use with forwarding: ID/EX holds lw to $5 and ID holds add reading $5 → one cycle of `pc_en`=0, `ifid_en`=0, `idex_flush`=1, then normal flow; `stall_cnt`=1. Without the macro, an add to $5 in EX/MEM also stalls.
- dwait plus redirect: `exmem_dREN`=1, `dhit`=0 for 4 cycles, `ex_redirect`=1 throughout → 4 freeze cycles with `memwb_flush`=1, then a redirect cycle; `flush_cnt`=1, `stall_cnt`=4.
- Icache miss: `ihit`=0 for 3 cycles → `pc_en`=0 and `ifid_flush`=1 for 3 cycles while downstream latches advance.
- Halt: `memwb_halt`=1 → younger latches flushed that cycle, `halted`=1 next cycle, all en=0 thereafter. Then assert RST → RUN, `halted`=0.
- Saturation: preload or run `stall_cnt` to 0xFFFFFFFF, then stall once more → it stays at 0xFFFFFFFF.
